cam_stream_gen: RTL and testbench

//  Transmit end of the OV7670-style parallel camera bus: drives PCLK, VSYNC, HREF and
//  8-bit data as RGB565 (high byte first), so camera_read and the frame-buffer path can
//  run in loopback/sim without a sensor. Runs from the 50 MHz system clock; pixel values

---
 rtl/cam_stream_gen_if.sv | 22 ++
 rtl/cam_stream_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_cam_stream_gen.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_stream_gen_if.sv
// cam_stream_gen_if: parallel camera bus (PCLK/VSYNC/HREF/data) plus the
// pixel lookup handshake (pix_x/pix_y out, pix_in back).
// master = transmitter (cam_stream_gen), slave = receiver / pixel source.
interface cam_stream_gen_if;
  logic        PCLK_cam;
  logic        VSYNC_cam;
  logic        HREF_cam;
  logic [7:0]  data_cam;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_in;

  modport master (
    output PCLK_cam, VSYNC_cam, HREF_cam, data_cam, pix_x, pix_y,
    input  pix_in
  );

  modport slave (
    input  PCLK_cam, VSYNC_cam, HREF_cam, data_cam, pix_x, pix_y,
    output pix_in
  );
endinterface

// File: rtl/cam_stream_gen.sv
// cam_stream_gen: OV7670-style camera bus transmitter (RGB565, high byte first).
// Optional colour-bar generator enabled by defining CAM_PATTERN_EN; without it
// pattern_sel is ignored and pix_in is always transmitted.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | PCLK held 0, waiting for enable
// S_START  | one lead-in PCLK period, bus blank, first byte tick ends it
// S_VSYNC  | VSYNC_cam high for V_SYNC lines
// S_VBACK  | blank lines after VSYNC
// S_ACTIVE | HREF lines carrying pixel bytes
// S_VFRONT | blank lines; end of last one pulses frame_done
module cam_stream_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 288,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic Clk,
  input  logic Reset,
  input  logic enable,
  input  logic pattern_sel,
  output logic busy,
  output logic frame_done,
  cam_stream_gen_if.master cam
);

  localparam int HALF     = CLK_DIV / 2;
  localparam int DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int BYTE_W   = $clog2(LINE_LEN);
  localparam int V_MAX_A  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int V_MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int LINE_W   = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(HALF - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(LINE_LEN - 1);
  localparam logic [BYTE_W-1:0] HREF_END  = BYTE_W'(2 * H_ACTIVE);
  localparam logic [9:0]        X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [8:0]        Y_LAST    = 9'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT
  } state_t;

  state_t              state, state_nx;
  logic [DIV_W-1:0]    div_cnt;
  logic                pclk;
  logic                tick;
  logic [BYTE_W-1:0]   byte_cnt, byte_nx;
  logic [LINE_W-1:0]   line_cnt, line_nx;
  logic                done_nx;
  logic                href_nx;
  logic                vsync_q, href_q;
  logic [7:0]          data_q, pix_lo;
  logic [9:0]          x_q;
  logic [8:0]          y_q;
  logic [15:0]         pix_sel;

`ifdef CAM_PATTERN_EN
  logic [2:0]  bar;
  logic [15:0] bar_rgb;

  assign bar = 3'((13'(cam.pix_x) * 13'd8) / 13'(H_ACTIVE));

  // colour of the bar containing the next pixel column
  always_comb begin
    bar_rgb = 16'h0000;
    case (bar)
      3'd0:    bar_rgb = 16'hFFFF;
      3'd1:    bar_rgb = 16'hFFE0;
      3'd2:    bar_rgb = 16'h07FF;
      3'd3:    bar_rgb = 16'h07E0;
      3'd4:    bar_rgb = 16'hF81F;
      3'd5:    bar_rgb = 16'hF800;
      3'd6:    bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
  end

  assign pix_sel = pattern_sel ? bar_rgb : cam.pix_in;
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign pix_sel = cam.pix_in;
`endif

  // the byte tick is the edge where PCLK falls
  assign tick = (state != S_IDLE) && (div_cnt == '0) && pclk;

  // PCLK divider: half-period down-counter, idle low
  always_ff @(posedge Clk) begin
    if (Reset || state == S_IDLE) begin
      div_cnt <= DIV_LOAD;
      pclk    <= 1'b0;
    end else if (div_cnt == '0) begin
      div_cnt <= DIV_LOAD;
      pclk    <= ~pclk;
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

  // state, byte slot and remaining-lines registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_cnt   <= byte_nx;
      line_cnt   <= line_nx;
      frame_done <= done_nx;
    end
  end

  // next state: counters describe the slot being driven after the tick
  always_comb begin
    state_nx = state;
    byte_nx  = byte_cnt;
    line_nx  = line_cnt;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nx = S_START;
          byte_nx  = '0;
          line_nx  = '0;
        end
      end
      S_START: begin
        if (tick) begin
          state_nx = S_VSYNC;
          byte_nx  = '0;
          line_nx  = LINE_W'(V_SYNC - 1);
        end
      end
      default: begin
        if (tick) begin
          if (byte_cnt == BYTE_LAST) begin
            byte_nx = '0;
            if (line_cnt == '0) begin
              case (state)
                S_VSYNC: begin
                  state_nx = S_VBACK;
                  line_nx  = LINE_W'(V_BACK - 1);
                end
                S_VBACK: begin
                  state_nx = S_ACTIVE;
                  line_nx  = LINE_W'(V_ACTIVE - 1);
                end
                S_ACTIVE: begin
                  state_nx = S_VFRONT;
                  line_nx  = LINE_W'(V_FRONT - 1);
                end
                default: begin
                  done_nx  = 1'b1;
                  state_nx = enable ? S_START : S_IDLE;
                  line_nx  = '0;
                end
              endcase
            end else begin
              line_nx = line_cnt - LINE_W'(1);
            end
          end else begin
            byte_nx = byte_cnt + BYTE_W'(1);
          end
        end
      end
    endcase
  end

  assign href_nx = (state_nx == S_ACTIVE) && (byte_nx < HREF_END);

  // bus outputs and pixel position update on byte ticks only
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      pix_lo  <= 8'h00;
      x_q     <= 10'd0;
      y_q     <= 9'd0;
    end else if (tick) begin
      vsync_q <= (state_nx == S_VSYNC);
      href_q  <= href_nx;
      if (href_nx) begin
        if (!byte_nx[0]) begin
          data_q <= pix_sel[15:8];
          pix_lo <= pix_sel[7:0];
        end else begin
          data_q <= pix_lo;
          if (x_q == X_LAST) begin
            x_q <= 10'd0;
            y_q <= (y_q == Y_LAST) ? 9'd0 : y_q + 9'd1;
          end else begin
            x_q <= x_q + 10'd1;
          end
        end
      end else begin
        data_q <= 8'h00;
      end
    end
  end

  assign busy          = (state != S_IDLE);
  assign cam.PCLK_cam  = pclk;
  assign cam.VSYNC_cam = vsync_q;
  assign cam.HREF_cam  = href_q;
  assign cam.data_cam  = data_q;
  assign cam.pix_x     = x_q;
  assign cam.pix_y     = y_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// tb_cam_stream_gen: checks cam_stream_gen against a slot-index model of the
// camera timing, plus a byte-level receiver with hand-computed expectations.
module tb_cam_stream_gen;

  localparam int CD   = 2;
  localparam int HALF = CD / 2;
`ifdef CAM_PATTERN_EN
  localparam int HA   = 16;
`else
  localparam int HA   = 4;
`endif
  localparam int HB   = 2;
  localparam int VS   = 1;
  localparam int VB   = 1;
  localparam int VA   = 2;
  localparam int VF   = 1;
  localparam int L    = 2 * HA + HB;
  localparam int FL   = (VS + VB + VA + VF) * L;
  localparam int FRAME_K = (FL + 1) * CD;
  localparam int LIMIT   = 4 * FRAME_K;

`ifdef CAM_PATTERN_EN
  localparam logic [15:0] BARS [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        enable = 1'b0;
  logic        pattern_sel = 1'b0;
  logic        busy, frame_done;
  logic [15:0] seed = 16'h0000;

  cam_stream_gen_if cam ();

  assign cam.pix_in = {cam.pix_y[6:0], cam.pix_x[8:0]} ^ seed;

  cam_stream_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS),
    .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .enable(enable), .pattern_sel(pattern_sel),
    .busy(busy), .frame_done(frame_done), .cam(cam)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int px, input int py);
    logic [31:0] ux, uy;
    ux = px;
    uy = py;
`ifdef CAM_PATTERN_EN
    if (pattern_sel) return BARS[(px * 8) / HA];
`endif
    return {uy[6:0], ux[8:0]} ^ seed;
  endfunction

  // inputs as the DUT saw them at the last rising edge
  logic rst_s = 1'b1;
  logic en_s  = 1'b0;
  always @(posedge Clk) begin
    rst_s <= Reset;
    en_s  <= enable;
  end

  // model state: running flag and Clk cycles since leaving idle
  bit chk_on = 0;
  bit m_run  = 0;
  int m_k    = 0;
  bit m_done = 0;

  // receiver and measurement state
  logic        prev_pclk = 1'b0;
  bit          rx_half = 0;
  logic [7:0]  rx_hi;
  logic [15:0] rx_q [$];
  bit          seen_vs = 0;
  int          vs_rises = 0, href_rises = 0, frame_rises = 0, done_cnt = 0;

  always @(negedge Clk) begin
    int m, s, line, b, la, p;
    logic        e_pclk, e_vs, e_href, e_busy;
    logic [7:0]  e_data;
    logic [15:0] px;
    m_done = 0;
    if (rst_s) begin
      m_run = 0;
      m_k   = 0;
    end else if (!m_run) begin
      if (en_s) begin
        m_run = 1;
        m_k   = 0;
      end
    end else begin
      m_k++;
      if (m_k == FRAME_K) begin
        m_done = 1;
        if (en_s) m_k = 0;
        else m_run = 0;
      end
    end

    e_pclk = 0; e_vs = 0; e_href = 0; e_data = 8'h00; p = 0;
    e_busy = m_run;
    if (m_run) begin
      e_pclk = ((m_k / HALF) % 2) == 1;
      m = m_k / CD;
      s = m - 1;
      if (m >= 1 && s < FL) begin
        line = s / L;
        b    = s % L;
        e_vs = (line < VS);
        la   = line - VS - VB;
        if (la >= 0 && la < VA && b < 2 * HA) begin
          e_href = 1;
          px     = exp_pix(b / 2, la);
          e_data = (b % 2 == 0) ? px[15:8] : px[7:0];
        end
        if (la < 0) p = 0;
        else if (la >= VA) p = VA * HA;
        else p = la * HA + (((b + 1) / 2 < HA) ? (b + 1) / 2 : HA);
      end
    end

    if (chk_on) begin
      chk("pclk", cam.PCLK_cam, e_pclk);
      chk("vsync", cam.VSYNC_cam, e_vs);
      chk("href", cam.HREF_cam, e_href);
      chk("data", cam.data_cam, e_data);
      chk("pix_x", cam.pix_x, p % HA);
      chk("pix_y", cam.pix_y, (p / HA) % VA);
      chk("busy", busy, e_busy);
      chk("frame_done", frame_done, m_done);
    end

    if (frame_done) done_cnt++;
    if (!prev_pclk && cam.PCLK_cam) begin
      if (cam.VSYNC_cam) begin
        seen_vs = 1;
        vs_rises++;
      end
      if (seen_vs) frame_rises++;
      if (cam.HREF_cam) begin
        href_rises++;
        if (!rx_half) rx_hi = cam.data_cam;
        else rx_q.push_back({rx_hi, cam.data_cam});
        rx_half = ~rx_half;
      end else begin
        rx_half = 0;
      end
    end
    prev_pclk = cam.PCLK_cam;
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!frame_done && c < LIMIT) begin
      cyc();
      c++;
    end
    chk(name, frame_done, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy && c < LIMIT) begin
      cyc();
      c++;
    end
    chk(name, busy, 1'b0);
  endtask

  initial begin
    int gap, c, ncyc;
    repeat (3) cyc();
    chk_on = 1;
    Reset  = 1'b0;
    cyc();
    chk("rst_busy", busy, 1'b0);
    chk("rst_pclk", cam.PCLK_cam, 1'b0);
    chk("rst_pix_x", cam.pix_x, 10'd0);

    // single frame with fixed pixel source, then back-to-back start
`ifdef CAM_PATTERN_EN
    pattern_sel = 1'b1;
`endif
    seed = 16'h0000;
    rx_q.delete();
    seen_vs = 0; vs_rises = 0; href_rises = 0; frame_rises = 0;
    enable = 1'b1;
    wait_done("frame1_done");
`ifdef CAM_PATTERN_EN
    chk("vsync_pclks", vs_rises, 34);
    chk("href_pclks", href_rises, 64);
    chk("frame_pclks", frame_rises, 170);
    chk("rx_count", rx_q.size(), 32);
    if (rx_q.size() >= 16) begin
      chk("bar_px0", rx_q[0], 16'hFFFF);
      chk("bar_px1", rx_q[1], 16'hFFFF);
      chk("bar_px2", rx_q[2], 16'hFFE0);
      chk("bar_px14", rx_q[14], 16'h0000);
      chk("bar_px15", rx_q[15], 16'h0000);
    end
`else
    chk("vsync_pclks", vs_rises, 10);
    chk("href_pclks", href_rises, 16);
    chk("frame_pclks", frame_rises, 50);
    chk("rx_count", rx_q.size(), 8);
    if (rx_q.size() >= 8) begin
      chk("rx_px0", rx_q[0], 16'h0000);
      chk("rx_px1", rx_q[1], 16'h0001);
      chk("rx_px3", rx_q[3], 16'h0003);
      chk("rx_row1_0", rx_q[4], 16'h0200);
      chk("rx_row1_3", rx_q[7], 16'h0203);
    end
`endif
    chk("wrap_pix_y", cam.pix_y, 9'd0);
    chk("wrap_busy", busy, 1'b1);
    gap = 0;
    while (!cam.VSYNC_cam && gap < LIMIT) begin
      cyc();
      gap++;
    end
    chk("b2b_gap_cycles", gap, 2);

    // drop enable during line 1: frame completes, then idle
    c = 0;
    while (cam.VSYNC_cam && c < LIMIT) begin
      cyc();
      c++;
    end
    chk("line1_reached", cam.VSYNC_cam, 1'b0);
    enable   = 1'b0;
    done_cnt = 0;
    wait_done("frame2_done");
    repeat (2 * FRAME_K) cyc();
    chk("one_done", done_cnt, 1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_pclk", cam.PCLK_cam, 1'b0);

    // reset held 5 cycles mid-active line
    seed   = 16'h5A3C;
    enable = 1'b1;
    c = 0;
    while (!cam.HREF_cam && c < LIMIT) begin
      cyc();
      c++;
    end
    chk("href_reached", cam.HREF_cam, 1'b1);
    repeat (3) cyc();
    Reset  = 1'b1;
    enable = 1'b0;
    repeat (5) cyc();
    chk("abort_pclk", cam.PCLK_cam, 1'b0);
    chk("abort_vsync", cam.VSYNC_cam, 1'b0);
    chk("abort_href", cam.HREF_cam, 1'b0);
    chk("abort_data", cam.data_cam, 8'h00);
    chk("abort_xy", {cam.pix_x, cam.pix_y}, 19'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", frame_done, 1'b0);
    Reset = 1'b0;
    repeat (4) cyc();
    chk("post_abort_busy", busy, 1'b0);

    // randomized enable toggling and reset pulses
    for (int it = 0; it < 8; it++) begin
      seed        = 16'($urandom);
      pattern_sel = 1'($urandom_range(0, 1));
      enable      = 1'b1;
      ncyc = $urandom_range(50, 3 * FRAME_K);
      for (int i = 0; i < ncyc; i++) begin
        cyc();
        if ($urandom_range(0, 63) == 0) enable = ~enable;
        if ($urandom_range(0, 299) == 0) begin
          Reset = 1'b1;
          repeat ($urandom_range(1, 5)) cyc();
          Reset = 1'b0;
        end
      end
      enable = 1'b0;
      wait_idle("rand_idle");
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
